maxpool_stream: RTL and testbench
=================================

# maxpool_stream

Streaming 2x2/stride-2 max-pooling stage that consumes the rectified feature maps produced by the ReLU layer. It reads one pixel position at a time, in raster order, for all channels in parallel. It emits one pooled value per 2x2 window over a valid/ready handshake. It sits between the ReLU layer and the fully-connected stage and reduces each 24x24 map to 12x12.

## Interface
- `DATA_WIDTH`, default 45: bits per channel sample.
- `IMG_W`, default 24: input columns; must be even.
- `IMG_H`, default 24: input rows; must be even.
- `CHANNELS`, default 8: lanes processed in parallel.

- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: begin consuming a frame. Connected to the ReLU done flag.
- `in_valid`  in  1: `in_data` holds a valid pixel.
- `in_ready`  out  1: block accepts a pixel this cycle.
- `in_data`  in  CHANNELS*DATA_WIDTH: lane c is `[c*DATA_WIDTH +: DATA_WIDTH]`.
- `out_valid`  out  1: `out_data` holds a pooled result.
- `out_ready`  in  1: downstream accepts the result.
- `out_data`  out  CHANNELS*DATA_WIDTH: pooled lanes, same packing as `in_data`.
- `pool_done`  out  1: one-cycle pulse after the last pooled result is accepted.

## Operation
- FSM states:
  - IDLE: wait for `start`.
  - RUN: consume pixels.
  - FLUSH: wait for the final output to be accepted.
  - DONE: assert `pool_done`.
- FSM transitions:
  - IDLE→RUN when `start`=1. Clear the row and column counters on entry.
  - RUN→FLUSH when the pixel at row IMG_H-1, column IMG_W-1 is accepted.
  - FLUSH→DONE when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1.
  - DONE→IDLE unconditionally after one cycle.
- `start` is ignored outside IDLE.
- `in_ready` = (state==RUN) && (!`out_valid` || `out_ready`).
- A pixel is accepted when `in_valid` && `in_ready`.
- Column counter 0..IMG_W-1 advances per accepted pixel. At IMG_W-1 it wraps to 0 and the row counter increments.
- Even column: capture the lanes into the pair register.
- Odd column: pair max = per-lane max(pair register, current pixel).
  - Even row: write the pair max into line buffer entry col/2. The buffer is IMG_W/2 entries of CHANNELS*DATA_WIDTH bits.
  - Odd row: result = per-lane max(pair max, line buffer[col/2]). Load it into the output register and set `out_valid`.
- Max comparison is unsigned over the full DATA_WIDTH, subject to the Configuration section. No width growth; results are exactly DATA_WIDTH per lane.
- Output register:
  - `out_valid` clears on `out_ready` unless a new result loads in the same cycle.
  - A simultaneous accept and new load keeps `out_valid`=1 with the new data.
- `out_data` is held stable while `out_valid`=1 and `out_ready`=0.
- A frame produces exactly (IMG_W/2)*(IMG_H/2) results (144 by default), in raster order of the pooled map.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`=0, `out_valid`=0, `out_data`=0, `pool_done`=0.
  - Counters 0, pair register 0, line buffer contents don't-care.
- Latency: `out_valid` rises on the cycle after the accepting edge of the odd-row/odd-column pixel.
- Throughput: 1 pixel/cycle with `out_ready` held high.
- Backpressure: `in_ready` drops in the same cycle that `out_valid`=1 and `out_ready`=0 (combinational).
- `pool_done` rises on the cycle after the FLUSH exit condition and lasts exactly 1 cycle.
- Reset mid-frame: `rst` has priority over all other inputs. It abandons the frame with no `pool_done` pulse, and all state returns to reset values on the next edge.

## Configuration
- `MAXPOOL_SIGN_CLAMP_EN` defined:
  - Every input lane whose MSB is 1 is treated as 0 before comparison.
  - This re-applies rectification, so a result is never negative.
- `MAXPOOL_SIGN_CLAMP_EN` undefined:
  - Lanes are compared as raw unsigned values.
  - An MSB-set input wins every comparison it takes part in.

## Test plan
- Ramp frame, lane c pixel = (row*24+col)+c, `out_ready`=1, no stalls:
  - 144 outputs.
  - First output lane 0 = 25; last output lane 0 = 575.
  - `pool_done` pulses 1 cycle after the last output.
- Single window with values 7, 3, 9, 2 (row0 col0/1, row1 col0/1), rest 0, all lanes:
  - First output = 9 in every lane.
- `out_ready` held 0 for 5 cycles when the first result appears:
  - `out_data` stable, `in_ready`=0 for those cycles.
  - No pixels lost; total output count still 144.
- Window containing 45'h1000_0000_0000 (MSB set) and 5, all other values 0:
  - With `MAXPOOL_SIGN_CLAMP_EN`, result = 5.
  - Without it, result = 45'h1000_0000_0000.
- `rst` asserted after 100 accepted pixels, then `start`, then a full ramp frame:
  - No `pool_done` for the aborted frame.
  - The new frame yields 144 correct outputs starting at 25.
- `start` pulsed while in RUN:
  - Ignored; counters continue; frame output unchanged.

Source files
------------

// File: rtl/maxpool_stream_if.sv
// maxpool_stream_if
//   Streaming bus for the 2x2 max-pooling stage: the pixel input stream and
//   the pooled output stream, each with a valid/ready handshake.
//   Lane c of either data bus is [c*DATA_WIDTH +: DATA_WIDTH].
// Signals
//   in_valid  : producer holds a valid pixel on in_data
//   in_ready  : pooling stage accepts a pixel this cycle
//   in_data   : CHANNELS lanes of DATA_WIDTH bits
//   out_valid : out_data holds a pooled result
//   out_ready : consumer accepts the result
//   out_data  : pooled lanes, same packing as in_data
// Modports
//   master : the side feeding pixels and draining results (upstream/downstream)
//   slave  : the pooling stage itself
interface maxpool_stream_if #(
  parameter int DATA_WIDTH = 45,
  parameter int CHANNELS   = 8
);
  logic                           in_valid;
  logic                           in_ready;
  logic [CHANNELS*DATA_WIDTH-1:0] in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [CHANNELS*DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/maxpool_stream.sv
// maxpool_stream
//   Streaming 2x2 / stride-2 max-pooling over CHANNELS parallel lanes.
//   Pixels arrive in raster order; one pooled result is emitted per 2x2
//   window, in raster order of the pooled map.
// Ports
//   clk       : clock
//   rst       : synchronous, active-high reset
//   start     : begin a frame (honoured only when idle)
//   pool_done : one-cycle pulse after the last pooled result is accepted
//   bus       : maxpool_stream_if.slave (pixel in / pooled result out)
// Build option
//   MAXPOOL_SIGN_CLAMP_EN : when defined, any input lane with its MSB set is
//   treated as 0 before comparison, so results are never negative. When
//   undefined, lanes are compared as raw unsigned values.
module maxpool_stream #(
  parameter int DATA_WIDTH = 45,
  parameter int IMG_W      = 24,
  parameter int IMG_H      = 24,
  parameter int CHANNELS   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             pool_done,
  maxpool_stream_if.slave  bus
);

  localparam int W  = CHANNELS * DATA_WIDTH;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t         state_q, state_nxt;
  logic [CW-1:0]  col_q;
  logic [RW-1:0]  row_q;
  logic [W-1:0]   pair_q;
  logic [W-1:0]   out_data_q;
  logic           out_valid_q;
  logic [W-1:0]   line_buf [IMG_W/2];

  logic [W-1:0]   clamped_in, pair_max, pool_res, lb_rd;
  logic           accept, last_pixel, load;

  function automatic logic [DATA_WIDTH-1:0] clamp(input logic [DATA_WIDTH-1:0] x);
`ifdef MAXPOOL_SIGN_CLAMP_EN
    return x[DATA_WIDTH-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  assign bus.in_ready  = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign pool_done     = (state_q == DONE);

  assign accept     = bus.in_valid && bus.in_ready;
  assign last_pixel = (row_q == ROW_LAST) && (col_q == COL_LAST);
  // Odd row and odd column closes a 2x2 window.
  assign load       = accept && col_q[0] && row_q[0];
  // col/2 selects the line-buffer slot shared by the two rows of a window.
  assign lb_rd      = line_buf[col_q[CW-1:1]];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [DATA_WIDTH-1:0] in_lane, pair_lane, lb_lane, pm;
    assign in_lane   = clamp(bus.in_data[c*DATA_WIDTH +: DATA_WIDTH]);
    assign pair_lane = pair_q[c*DATA_WIDTH +: DATA_WIDTH];
    assign lb_lane   = lb_rd[c*DATA_WIDTH +: DATA_WIDTH];
    assign pm        = (pair_lane > in_lane) ? pair_lane : in_lane;
    assign clamped_in[c*DATA_WIDTH +: DATA_WIDTH] = in_lane;
    assign pair_max[c*DATA_WIDTH +: DATA_WIDTH]   = pm;
    assign pool_res[c*DATA_WIDTH +: DATA_WIDTH]   = (pm > lb_lane) ? pm : lb_lane;
  end

  always_comb begin
    // NOTE: assigning the default first means every path drives state_nxt, so no latch is inferred.
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && last_pixel) state_nxt = FLUSH;
      FLUSH:   if (!out_valid_q || bus.out_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values, avoiding order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q <= state_nxt;

      if (state_q == IDLE && start) begin
        col_q <= '0;
        row_q <= '0;
      end else if (accept) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
        if (!col_q[0]) pair_q <= clamped_in;
      end

      // A new load wins over a same-cycle drain, so out_valid stays high.
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= pool_res;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: the line buffer has no reset; every slot is written on an even row before any odd row reads it.
  always_ff @(posedge clk) begin
    if (accept && col_q[0] && !row_q[0]) line_buf[col_q[CW-1:1]] <= pair_max;
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// tb_maxpool_stream
//   Self-checking bench for maxpool_stream: ramp frames, a table of
//   single-window vectors, output backpressure, start while running, and
//   reset in the middle of a frame.
module tb_maxpool_stream;
  localparam int DW   = 45;
  localparam int CH   = 8;
  localparam int IW   = 24;
  localparam int IH   = 24;
  localparam int W    = DW * CH;
  localparam int NOUT = (IW / 2) * (IH / 2);
  localparam int NPIX = IW * IH;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic pool_done;

  always #5 clk = ~clk;

  maxpool_stream_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus ();

  maxpool_stream #(
    .DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH), .CHANNELS(CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pool_done (pool_done),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    string         name;
    logic [DW-1:0] a, b, c, d;   // row0 col0, row0 col1, row1 col0, row1 col1
    logic [DW-1:0] exp;
  } win_vec_t;

  win_vec_t vecs[6];

  int            mode;           // 0 = ramp frame, 1 = single-window frame
  logic [DW-1:0] wa, wb, wc, wd, wexp;

  function automatic logic [DW-1:0] pix_lane(input int r, input int col, input int lane);
    if (mode == 0) return DW'(r * IW + col + lane);
    if (r == 0 && col == 0) return wa;
    if (r == 0 && col == 1) return wb;
    if (r == 1 && col == 0) return wc;
    if (r == 1 && col == 1) return wd;
    return '0;
  endfunction

  function automatic logic [W-1:0] pix_word(input int p);
    logic [W-1:0] w;
    w = '0;
    for (int l = 0; l < CH; l++) w[l*DW +: DW] = pix_lane(p / IW, p % IW, l);
    return w;
  endfunction

  function automatic logic [W-1:0] exp_word(input int k);
    logic [W-1:0] w;
    int i, j;
    i = k / (IW / 2);
    j = k % (IW / 2);
    w = '0;
    for (int l = 0; l < CH; l++) begin
      if (mode == 0) w[l*DW +: DW] = DW'((2*i + 1) * IW + (2*j + 1) + l);
      else           w[l*DW +: DW] = (k == 0) ? wexp : '0;
    end
    return w;
  endfunction

  // One frame, cycle by cycle: inputs are driven on the falling edge and
  // both handshakes are evaluated just after, before the next rising edge.
  task automatic run_frame(input string tag, input int stall_n, input int start_mid_at,
                           input int abort_at);
    int pix = 0, outs = 0, cyc = 0, pd_cnt = 0, pd_cyc = -1, last_out_cyc = -1;
    int stall_left = stall_n, acc_first = -1, acc_last = -1, win_acc = -1, ov_first = -1;
    logic [W-1:0] held = '0;
    bit done = 0, aborted = 0;

    @(negedge clk);
    start = 1'b1;
    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (pool_done) begin
        pd_cnt++;
        pd_cyc = cyc;
      end
      if (pd_cyc >= 0 && cyc >= pd_cyc + 2) done = 1;
      if (bus.out_valid && ov_first < 0) ov_first = cyc;

      if (abort_at >= 0 && pix >= abort_at) begin
        bus.in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) begin
          @(negedge clk);
          if (pool_done) pd_cnt++;
        end
        rst = 1'b0;
        @(negedge clk);
        if (pool_done) pd_cnt++;
        check({tag, " pool_done_count"}, W'(pd_cnt), W'(0));
        check({tag, " out_valid_after_rst"}, W'(bus.out_valid), W'(0));
        check({tag, " out_data_after_rst"}, bus.out_data, '0);
        check({tag, " in_ready_after_rst"}, W'(bus.in_ready), W'(0));
        aborted = 1;
        done = 1;
      end else begin
        if (start_mid_at >= 0 && pix == start_mid_at) start = 1'b1;

        if (bus.out_valid && stall_left > 0) begin
          if (stall_left == stall_n) held = bus.out_data;
          else check({tag, " stall_hold"}, bus.out_data, held);
          bus.out_ready = 1'b0;
          stall_left--;
        end else begin
          bus.out_ready = 1'b1;
        end

        bus.in_valid = (pix < NPIX);
        bus.in_data  = (pix < NPIX) ? pix_word(pix) : '0;
        #1;
        if (!bus.out_ready) check({tag, " stall_in_ready"}, W'(bus.in_ready), W'(0));
        if (bus.out_valid && bus.out_ready) begin
          if (outs < NOUT) check($sformatf("%s out%0d", tag, outs), bus.out_data, exp_word(outs));
          outs++;
          last_out_cyc = cyc;
        end
        if (bus.in_valid && bus.in_ready) begin
          if (acc_first < 0) acc_first = cyc;
          if (pix == IW + 1) win_acc = cyc;
          acc_last = cyc;
          pix++;
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    start         = 1'b0;

    if (!aborted) begin
      check({tag, " finished"}, W'(done), W'(1));
      check({tag, " out_count"}, W'(outs), W'(NOUT));
      check({tag, " pool_done_count"}, W'(pd_cnt), W'(1));
      check({tag, " pool_done_timing"}, W'(pd_cyc), W'(last_out_cyc + 1));
      check({tag, " first_latency"}, W'(ov_first), W'(win_acc + 1));
      if (stall_n == 0) check({tag, " throughput"}, W'(acc_last - acc_first), W'(NPIX - 1));
    end
  endtask

  initial begin
    vecs[0] = '{name: "win_7_3_9_2", a: 45'd7, b: 45'd3, c: 45'd9, d: 45'd2, exp: 45'd9};
    vecs[1] = '{name: "win_last",    a: 45'd1, b: 45'd2, c: 45'd3, d: 45'd4, exp: 45'd4};
    vecs[2] = '{name: "win_first",   a: 45'h0FFF_FFFF_FFFF, b: 45'd0, c: 45'd0, d: 45'd1,
                exp: 45'h0FFF_FFFF_FFFF};
`ifdef MAXPOOL_SIGN_CLAMP_EN
    vecs[3] = '{name: "win_sign",    a: 45'h1000_0000_0000, b: 45'd5, c: 45'd0, d: 45'd0,
                exp: 45'd5};
    vecs[4] = '{name: "win_sign_mix", a: 45'd0, b: 45'd0, c: 45'h1FFF_FFFF_FFFF, d: 45'h11,
                exp: 45'h11};
`else
    vecs[3] = '{name: "win_sign",    a: 45'h1000_0000_0000, b: 45'd5, c: 45'd0, d: 45'd0,
                exp: 45'h1000_0000_0000};
    vecs[4] = '{name: "win_sign_mix", a: 45'd0, b: 45'd0, c: 45'h1FFF_FFFF_FFFF, d: 45'h11,
                exp: 45'h1FFF_FFFF_FFFF};
`endif
    vecs[5] = '{name: "win_zero",    a: 45'd0, b: 45'd0, c: 45'd0, d: 45'd0, exp: 45'd0};

    rst           = 1'b1;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    mode          = 0;
    wa = '0; wb = '0; wc = '0; wd = '0; wexp = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", W'(bus.in_ready), W'(0));
    check("reset out_valid", W'(bus.out_valid), W'(0));
    check("reset out_data", bus.out_data, '0);
    check("reset pool_done", W'(pool_done), W'(0));

    mode = 0;
    run_frame("ramp", 0, -1, -1);

    mode = 1;
    for (int v = 0; v < 6; v++) begin
      wa = vecs[v].a; wb = vecs[v].b; wc = vecs[v].c; wd = vecs[v].d; wexp = vecs[v].exp;
      run_frame(vecs[v].name, 0, -1, -1);
    end

    mode = 0;
    run_frame("stall", 5, -1, -1);
    run_frame("start_mid", 0, 50, -1);
    run_frame("abort", 0, -1, 100);
    run_frame("after_abort", 0, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
